// File: rtl/cd_4532.sv
// rtl/cd_4532.sv - 3-to-8 line decoder with active-low outputs and optional output register
//
// Purpose:
//   Decodes the 3-bit select A onto eight active-low lines Y. The decoder is
//   enabled only when E == 3'b100, that is G1 high, G2A_n low and G2B_n low.
//   When enabled, Y[A] is 0 and every other bit is 1. When disabled, Y is 8'hFF.
//
// Parameters:
//   OUT_REG - 1: Y is registered on clk, with one cycle of latency and a
//                synchronous active-high rst that forces Y to 8'hFF.
//             0: Y is purely combinational, and clk/rst are ignored.
//
// Ports:
//   clk  in   1  clock; state updates on the rising edge
//   rst  in   1  synchronous active-high reset
//   E    in   3  enable group {G1, G2A_n, G2B_n}
//   A    in   3  binary select, A[0] = LSB
//   Y    out  8  decoded outputs, active-low; Y[i] is low for A == i

module cd_4532 #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] E,
    input  logic [2:0] A,
    output logic [7:0] Y
);

    logic       enabled;
    logic [7:0] y_next;

    assign enabled = (E == 3'b100);

    always_comb begin
        y_next = 8'hFF;
        if (enabled) begin
            y_next[A] = 1'b0;
        end
    end

    generate
        if (OUT_REG) begin : g_reg
            // Reset takes priority over decode. A is never held while the
            // decoder is disabled, so the first enabled edge decodes the A
            // present at that edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    Y <= 8'hFF;
                end else begin
                    Y <= y_next;
                end
            end
        end else begin : g_comb
            assign Y = y_next;
        end
    endgenerate

endmodule

// File: tb/tb_cd_4532.sv
// tb/tb_cd_4532.sv - directed table-driven bench for cd_4532, registered and combinational builds

module tb_cd_4532;

    logic       clk;
    logic       rst;
    logic [2:0] e_r;
    logic [2:0] a_r;
    logic [7:0] y_r;
    logic [2:0] e_c;
    logic [2:0] a_c;
    logic [7:0] y_c;

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic [2:0] e;
        logic [2:0] a;
        logic [7:0] y;
        string      name;
    } vec_t;

    vec_t vecs[$];

    cd_4532 #(.OUT_REG(1'b1)) dut_reg (
        .clk (clk),
        .rst (rst),
        .E   (e_r),
        .A   (a_r),
        .Y   (y_r)
    );

    cd_4532 #(.OUT_REG(1'b0)) dut_comb (
        .clk (clk),
        .rst (rst),
        .E   (e_c),
        .A   (a_c),
        .Y   (y_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] e, input logic [2:0] a,
                       input logic [7:0] y, input string name);
        vec_t v;
        v.rst  = r;
        v.e    = e;
        v.a    = a;
        v.y    = y;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        e_r      = 3'b100;
        a_r      = 3'b011;
        e_c      = 3'b000;
        a_c      = 3'b000;

        // Reset check, then release
        add(1'b1, 3'b100, 3'b011, 8'hFF, "reset_c1");
        add(1'b1, 3'b100, 3'b011, 8'hFF, "reset_c2");
        add(1'b0, 3'b100, 3'b011, 8'hF7, "reset_release");
        // Enable sweep
        add(1'b0, 3'b100, 3'd0, 8'hFE, "sweep_a0");
        add(1'b0, 3'b100, 3'd1, 8'hFD, "sweep_a1");
        add(1'b0, 3'b100, 3'd2, 8'hFB, "sweep_a2");
        add(1'b0, 3'b100, 3'd3, 8'hF7, "sweep_a3");
        add(1'b0, 3'b100, 3'd4, 8'hEF, "sweep_a4");
        add(1'b0, 3'b100, 3'd5, 8'hDF, "sweep_a5");
        add(1'b0, 3'b100, 3'd6, 8'hBF, "sweep_a6");
        add(1'b0, 3'b100, 3'd7, 8'h7F, "sweep_a7");
        // Disabled at A=000
        add(1'b0, 3'b000, 3'b000, 8'hFF, "dis_e000_a0");
        add(1'b0, 3'b010, 3'b000, 8'hFF, "dis_e010_a0");
        add(1'b0, 3'b001, 3'b000, 8'hFF, "dis_e001_a0");
        // Disabled at A=101, every non-100 enable code
        add(1'b0, 3'b000, 3'b101, 8'hFF, "dis_e000_a5");
        add(1'b0, 3'b001, 3'b101, 8'hFF, "dis_e001_a5");
        add(1'b0, 3'b010, 3'b101, 8'hFF, "dis_e010_a5");
        add(1'b0, 3'b011, 3'b101, 8'hFF, "dis_e011_a5");
        add(1'b0, 3'b101, 3'b101, 8'hFF, "dis_e101_a5");
        add(1'b0, 3'b110, 3'b101, 8'hFF, "dis_e110_a5");
        add(1'b0, 3'b111, 3'b101, 8'hFF, "dis_e111_a5");
        // Re-enable uses the A present at that same edge
        add(1'b0, 3'b100, 3'b101, 8'hDF, "reenable_a5");
        // Mid-run reset
        add(1'b0, 3'b100, 3'b110, 8'hBF, "mid_pre");
        add(1'b1, 3'b100, 3'b110, 8'hFF, "mid_rst1");
        add(1'b1, 3'b100, 3'b110, 8'hFF, "mid_rst2");
        add(1'b0, 3'b100, 3'b110, 8'hBF, "mid_release");

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            e_r = vecs[i].e;
            a_r = vecs[i].a;
            @(posedge clk);
            #1;
            check(vecs[i].name, y_r, vecs[i].y);
        end

        // Latency/hold: Y is BF here. Change A between edges, Y must not move.
        @(negedge clk);
        a_r = 3'b001;
        #1;
        check("hold_after_a_change", y_r, 8'hBF);
        e_r = 3'b111;
        #1;
        check("hold_after_e_change", y_r, 8'hBF);
        e_r = 3'b100;
        @(posedge clk);
        #1;
        check("edge_new_decode", y_r, 8'hFD);
        #2;
        a_r = 3'b111;
        #1;
        check("hold_post_edge", y_r, 8'hFD);
        @(posedge clk);
        #1;
        check("edge_after_post_change", y_r, 8'h7F);

        // Combinational build: no clock edge is needed
        @(negedge clk);
        e_c = 3'b100; a_c = 3'b010;
        #1;
        check("comb_e100_a2", y_c, 8'hFB);
        e_c = 3'b110;
        #1;
        check("comb_e110_a2", y_c, 8'hFF);
        e_c = 3'b100; a_c = 3'b000;
        #1;
        check("comb_e100_a0", y_c, 8'hFE);
        a_c = 3'b111;
        #1;
        check("comb_e100_a7", y_c, 8'h7F);
        e_c = 3'b101;
        #1;
        check("comb_e101_a7", y_c, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
